// File: rtl/load_store_unit.sv
// Load/store unit between the EX stage and a single-port data memory.
// One request in flight: IDLE accepts, ACCESS waits for mem_ack (bounded by TIMEOUT), RESP emits one response.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_regwrite,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            cnt_q, cnt_d;

  logic                  req_err;
  logic                  timeout_hit;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;

  // Illegal size/sign encodings and misaligned accesses are rejected up front.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      req_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      req_err = req_funct3 inside {3'b011, 3'b110, 3'b111};
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
      req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
      req_err = 1'b1;
    end
  end

  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          err_d    = req_err;
          state_d  = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // An ack arriving in the last permitted cycle still completes normally.
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign lane_b = rdata_q[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = rdata_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    req_ready    = 1'b0;
    busy         = 1'b1;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_rd       = '0;
    rsp_regwrite = 1'b0;
    rsp_err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ACCESS: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
        unique case (funct3_q[1:0])
          2'b00: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {(DATA_WIDTH/8){wdata_q[7:0]}};
          end
          2'b01: begin
            mem_be    = 4'b0011 << addr_q[1:0];
            mem_wdata = {(DATA_WIDTH/16){wdata_q[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rd    = rd_q;
        rsp_err   = err_q;
        if (!err_q && !we_q) begin
          rsp_regwrite = 1'b1;
          unique case (funct3_q)
            3'b000:  rsp_rdata = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
            3'b001:  rsp_rdata = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
            3'b100:  rsp_rdata = {{(DATA_WIDTH-8){1'b0}}, lane_b};
            3'b101:  rsp_rdata = {{(DATA_WIDTH-16){1'b0}}, lane_h};
            default: rsp_rdata = rdata_q;
          endcase
        end
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles awaiting mem_ack (range 2..255).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req_valid  input  1  EX stage presents a memory op.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RISC-V funct3 (size/sign).
REQ-009 SHALL have port req_addr  input  DATA_WIDTH  byte address (ALU ADD result).
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port req_rd  input  5  load destination register.
REQ-012 SHALL have ports mem_req/mem_we output 1; mem_addr/mem_wdata output DATA_WIDTH; mem_be output 4: data-memory request.
REQ-013 SHALL have ports mem_ack input 1, mem_rdata input DATA_WIDTH: memory completion and read word.
REQ-014 SHALL have ports rsp_valid out 1, rsp_rdata out DATA_WIDTH, rsp_rd out 5, rsp_regwrite out 1, rsp_err out 1, busy out 1.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready=1 and busy=0 only in IDLE.
REQ-016 SHALL capture request fields into registers on req_valid&&req_ready; captured fields SHALL not change until the next return to IDLE.
REQ-017 SHALL classify as error: load funct3 in {011,110,111}; store funct3 not in {000,001,010}; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-018 SHALL on an accepted error request go IDLE->RESP directly, never asserting mem_req.
REQ-019 SHALL on an accepted legal request go IDLE->ACCESS; mem_req=1 from the next cycle through the cycle mem_ack is sampled high.
REQ-020 SHALL drive mem_addr={addr[31:2],2'b00}, mem_we=captured req_we, stable throughout ACCESS.
REQ-021 SHALL drive mem_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; loads also drive this mask.
REQ-022 SHALL replicate store data: byte wdata[7:0] x4, half wdata[15:0] x2, word unchanged.
REQ-023 SHALL register mem_rdata on the ack cycle and go ACCESS->RESP.
REQ-024 SHALL count ACCESS cycles from 0; if mem_ack is low in the TIMEOUT-th ACCESS cycle, go to RESP with error; ack in that same cycle wins.
REQ-025 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE; no backpressure on the response.
REQ-026 SHALL extract load lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-027 SHALL drive rsp_regwrite=1 only for error-free loads; rsp_rd=captured rd; rsp_rdata=0 for stores and errors.
REQ-028 SHALL hold rsp_err, rsp_rdata, rsp_regwrite at 0 whenever rsp_valid=0.
REQ-029 SHALL ignore mem_ack outside ACCESS.
REQ-030 SHALL sustain one request per three cycles at zero-wait memory (accept, ACCESS with ack, RESP).

Reset
REQ-031 SHALL on reset=0 immediately force IDLE, counter 0, all outputs 0 except req_ready=1, including mid-ACCESS.
REQ-032 SHALL accept a request in the first rising edge after reset deasserts.

Verification
REQ-033 LB addr 0x1003, ack 2 cycles later with rdata 0x80FF1234 -> mem_be 1000, rsp_rdata 0xFFFFFF80, rsp_regwrite 1; LBU -> 0x00000080.
REQ-034 SH addr 0x2002, wdata 0x0000ABCD -> mem_addr 0x2000, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1, rsp_regwrite 0.
REQ-035 LW addr 0x1001 accepted cycle N -> mem_req never 1, rsp_valid and rsp_err 1 at N+1.
REQ-036 TIMEOUT=4, mem_ack held 0 -> mem_req high 4 cycles, then rsp_valid=1, rsp_err=1; ack on 4th cycle -> rsp_err=0.
REQ-037 reset=0 during ACCESS -> mem_req 0 without waiting for clk, req_ready 1; late mem_ack ignored.
REQ-038 back-to-back LW 0x0, SW 0x4, zero-wait ack -> requests accepted every 3 cycles, rsp_valid pulses separated by 2 idle cycles.
